uart_core: RTL and testbench

- Parametrised full-duplex UART core: replaces the separate clk_divider / uart_rx / uart_tx arrangement with one block.
- Contents: shared 16x-oversampling baud generator, TX framer with valid/ready handshake, RX deframer with 2-FF synchroniser and start-bit validation, and a receive FIFO.
- Runtime-configurable speed, parity and stop bits.
- Sits between the serial pins and the packet/control logic (control_uart, LCD path).

---
 rtl/uart_core.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// uart_core: full-duplex UART with a shared 16x baud generator, TX framer, RX deframer and RX FIFO.
// Build option UART_LOOPBACK_EN adds a loopback input that routes the TX stream into RX internally.
module uart_core #(
  parameter int CLK_HZ     = 50000000,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef UART_LOOPBACK_EN
  input  logic                          loopback,
`endif
  input  logic                          rx,
  output logic                          tx,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  input  logic [1:0]                    cfg_speed,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          cfg_load,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [2:0]                    o_dbg_tx_state,
  output logic [2:0]                    o_dbg_rx_state
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(DATA_BITS);
  localparam int DIV0 = CLK_HZ / (9600 * 16);
  localparam int DIV1 = CLK_HZ / (19200 * 16);
  localparam int DIV2 = CLK_HZ / (57600 * 16);
  localparam int DIV3 = CLK_HZ / (115200 * 16);
  localparam int BW   = $clog2(DIV0) + 1;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // ---------------- configuration and baud generator ----------------
  logic [1:0]    r_cfg_speed, r_cfg_parity, r_pend_speed, r_pend_parity;
  logic          r_cfg_stop2, r_pend_stop2, r_pend;
  logic [BW-1:0] r_baud_cnt, w_div_m1;
  logic          w_tick, w_idle, w_apply, w_par_en, w_par_odd;
  tx_state_t     r_tx_state, w_tx_state_nx;
  rx_state_t     r_rx_state, w_rx_state_nx;

  assign w_idle    = (r_tx_state == TX_IDLE) && (r_rx_state == RX_IDLE);
  assign w_apply   = (cfg_load | r_pend) & w_idle;
  assign w_par_en  = (r_cfg_parity == 2'b01) || (r_cfg_parity == 2'b10);
  assign w_par_odd = (r_cfg_parity == 2'b10);

  always_comb begin
    w_div_m1 = BW'(DIV3 - 1);
    unique case (r_cfg_speed)
      2'b00:   w_div_m1 = BW'(DIV0 - 1);
      2'b01:   w_div_m1 = BW'(DIV1 - 1);
      2'b10:   w_div_m1 = BW'(DIV2 - 1);
      default: w_div_m1 = BW'(DIV3 - 1);
    endcase
  end

  assign w_tick = (r_baud_cnt == w_div_m1);

  // A request arriving while busy is parked; a newer request overwrites the parked one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cfg_speed   <= 2'b11;
      r_cfg_parity  <= 2'b00;
      r_cfg_stop2   <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_speed  <= 2'b11;
      r_pend_parity <= 2'b00;
      r_pend_stop2  <= 1'b0;
      r_baud_cnt    <= '0;
    end else begin
      if (cfg_load) begin
        r_pend_speed  <= cfg_speed;
        r_pend_parity <= cfg_parity;
        r_pend_stop2  <= cfg_stop2;
      end
      r_pend <= (cfg_load | r_pend) & ~w_idle;
      if (w_apply) begin
        r_cfg_speed  <= cfg_load ? cfg_speed  : r_pend_speed;
        r_cfg_parity <= cfg_load ? cfg_parity : r_pend_parity;
        r_cfg_stop2  <= cfg_load ? cfg_stop2  : r_pend_stop2;
      end
      if (w_apply || w_tick) r_baud_cnt <= '0;
      else                   r_baud_cnt <= r_baud_cnt + BW'(1);
    end
  end

  // ---------------- transmitter ----------------
  logic [DATA_BITS-1:0] r_tx_data, r_tx_shift, w_tx_data_nx, w_tx_shift_nx;
  logic [3:0]           r_tx_ticks, w_tx_ticks_nx;
  logic [CW-1:0]        r_tx_bits, w_tx_bits_nx;
  logic                 r_tx_armed, w_tx_armed_nx, r_tx_line, w_tx_line_nx;
  logic                 w_tx_bit_end, w_tx_par, w_tx_ready;

  assign w_tx_bit_end = w_tick & r_tx_armed & (r_tx_ticks == 4'd15);
  assign w_tx_par     = (^r_tx_data) ^ w_par_odd;

  // The line only goes low once the first tick after acceptance arms the frame.
  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_data_nx  = r_tx_data;
    w_tx_shift_nx = r_tx_shift;
    w_tx_ticks_nx = r_tx_ticks;
    w_tx_bits_nx  = r_tx_bits;
    w_tx_armed_nx = r_tx_armed;
    w_tx_line_nx  = r_tx_line;
    w_tx_ready    = 1'b0;
    if (w_tick && r_tx_armed && r_tx_state != TX_IDLE) w_tx_ticks_nx = r_tx_ticks + 4'd1;
    unique case (r_tx_state)
      TX_IDLE: begin
        w_tx_ready = 1'b1;
        if (tx_valid) begin
          w_tx_state_nx = TX_START;
          w_tx_data_nx  = tx_data;
          w_tx_shift_nx = tx_data;
          w_tx_armed_nx = 1'b0;
          w_tx_ticks_nx = '0;
        end
      end
      TX_START: begin
        if (w_tick && !r_tx_armed) begin
          w_tx_armed_nx = 1'b1;
          w_tx_line_nx  = 1'b0;
        end else if (w_tx_bit_end) begin
          w_tx_state_nx = TX_DATA;
          w_tx_bits_nx  = '0;
          w_tx_line_nx  = r_tx_shift[0];
        end
      end
      TX_DATA: begin
        if (w_tx_bit_end) begin
          if (r_tx_bits == CW'(DATA_BITS - 1)) begin
            w_tx_state_nx = w_par_en ? TX_PARITY : TX_STOP1;
            w_tx_line_nx  = w_par_en ? w_tx_par : 1'b1;
          end else begin
            w_tx_bits_nx  = r_tx_bits + CW'(1);
            w_tx_shift_nx = r_tx_shift >> 1;
            w_tx_line_nx  = r_tx_shift[1];
          end
        end
      end
      TX_PARITY: begin
        if (w_tx_bit_end) begin
          w_tx_state_nx = TX_STOP1;
          w_tx_line_nx  = 1'b1;
        end
      end
      TX_STOP1: if (w_tx_bit_end) w_tx_state_nx = r_cfg_stop2 ? TX_STOP2 : TX_IDLE;
      TX_STOP2: if (w_tx_bit_end) w_tx_state_nx = TX_IDLE;
      default:  w_tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_data  <= '0;
      r_tx_shift <= '0;
      r_tx_ticks <= '0;
      r_tx_bits  <= '0;
      r_tx_armed <= 1'b0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_data  <= w_tx_data_nx;
      r_tx_shift <= w_tx_shift_nx;
      r_tx_ticks <= w_tx_ticks_nx;
      r_tx_bits  <= w_tx_bits_nx;
      r_tx_armed <= w_tx_armed_nx;
      r_tx_line  <= w_tx_line_nx;
    end
  end

  logic w_rx_pin;
`ifdef UART_LOOPBACK_EN
  assign tx       = loopback ? 1'b1 : r_tx_line;
  assign w_rx_pin = loopback ? r_tx_line : rx;
`else
  assign tx       = r_tx_line;
  assign w_rx_pin = rx;
`endif
  assign tx_ready = w_tx_ready;

  // ---------------- receiver ----------------
  logic                 r_rx_s1, r_rx_s2, r_rx_prev;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nx;
  logic [3:0]           r_rx_ticks, w_rx_ticks_nx;
  logic [CW-1:0]        r_rx_bits, w_rx_bits_nx;
  logic                 r_rx_par_bit, w_rx_par_bit_nx;
  logic                 r_push, r_parity_err, r_frame_err;
  logic                 w_push_nx, w_perr_nx, w_ferr_nx, w_rx_sample, w_rx_bit_end;

  // Ticks free-run, so the sample lands within one tick of the true bit centre.
  assign w_rx_sample  = w_tick & (r_rx_ticks == 4'd7);
  assign w_rx_bit_end = w_tick & (r_rx_ticks == 4'd15);

  always_comb begin
    w_rx_state_nx   = r_rx_state;
    w_rx_shift_nx   = r_rx_shift;
    w_rx_ticks_nx   = r_rx_ticks;
    w_rx_bits_nx    = r_rx_bits;
    w_rx_par_bit_nx = r_rx_par_bit;
    w_push_nx       = 1'b0;
    w_perr_nx       = 1'b0;
    w_ferr_nx       = 1'b0;
    if (w_tick && r_rx_state != RX_IDLE) w_rx_ticks_nx = r_rx_ticks + 4'd1;
    unique case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_s2) begin
          w_rx_state_nx = RX_START;
          w_rx_ticks_nx = '0;
        end
      end
      RX_START: begin
        if (w_rx_sample && r_rx_s2) begin
          w_rx_state_nx = RX_IDLE;
        end else if (w_rx_bit_end) begin
          w_rx_state_nx = RX_DATA;
          w_rx_bits_nx  = '0;
        end
      end
      RX_DATA: begin
        if (w_rx_sample) w_rx_shift_nx = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
        if (w_rx_bit_end) begin
          if (r_rx_bits == CW'(DATA_BITS - 1)) w_rx_state_nx = w_par_en ? RX_PARITY : RX_STOP;
          else                                 w_rx_bits_nx  = r_rx_bits + CW'(1);
        end
      end
      RX_PARITY: begin
        if (w_rx_sample)  w_rx_par_bit_nx = r_rx_s2;
        if (w_rx_bit_end) w_rx_state_nx   = RX_STOP;
      end
      RX_STOP: begin
        // Finishing at mid-stop leaves time to catch a back-to-back start edge.
        if (w_rx_sample) begin
          w_rx_state_nx = RX_IDLE;
          w_push_nx     = r_rx_s2;
          w_ferr_nx     = ~r_rx_s2;
          w_perr_nx     = w_par_en & (r_rx_par_bit != ((^r_rx_shift) ^ w_par_odd));
        end
      end
      default: w_rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_rx_shift   <= '0;
      r_rx_ticks   <= '0;
      r_rx_bits    <= '0;
      r_rx_par_bit <= 1'b0;
      r_push       <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_s1      <= w_rx_pin;
      r_rx_s2      <= r_rx_s1;
      r_rx_prev    <= r_rx_s2;
      r_rx_state   <= w_rx_state_nx;
      r_rx_shift   <= w_rx_shift_nx;
      r_rx_ticks   <= w_rx_ticks_nx;
      r_rx_bits    <= w_rx_bits_nx;
      r_rx_par_bit <= w_rx_par_bit_nx;
      r_push       <= w_push_nx;
      r_parity_err <= w_perr_nx;
      r_frame_err  <= w_ferr_nx;
    end
  end

  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;

  // ---------------- receive FIFO (first-word-fall-through) ----------------
  // r_rx_shift is stable in the cycle after the stop sample, so it is the push data.
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_overrun, w_full, w_pop, w_wr;

  assign w_full = (r_count == (AW + 1)'(FIFO_DEPTH));
  assign w_pop  = rx_ready & (r_count != '0);
  assign w_wr   = r_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_rx_shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + (AW + 1)'(1);
      else if (!w_wr && w_pop) r_count <= r_count - (AW + 1)'(1);
      if (r_push && w_full && !w_pop) r_overrun <= 1'b1;
      else if (w_pop || w_apply)      r_overrun <= 1'b0;
    end
  end

  assign rx_data        = r_mem[r_rd_ptr];
  assign rx_valid       = (r_count != '0);
  assign rx_count       = r_count;
  assign overrun        = r_overrun;
  assign o_dbg_tx_state = r_tx_state;
  assign o_dbg_rx_state = r_rx_state;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: a 50 MHz instance for TX timing/reconfiguration/reset,
// and a 3.6864 MHz instance (32 clocks per bit at 115200) for RX, FIFO and error cases.
module tb_uart_core;
  localparam int FAST_HZ = 3686400;
  localparam int FBIT    = 32;
  localparam int SBIT    = 432;
  localparam int SBIT0   = 5200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slow (50 MHz) instance ----------------
  logic       s_rx, s_tx, s_tx_valid, s_tx_ready, s_rx_valid, s_rx_ready;
  logic [7:0] s_tx_data, s_rx_data;
  logic [4:0] s_rx_count;
  logic [1:0] s_cfg_speed, s_cfg_parity;
  logic       s_cfg_stop2, s_cfg_load, s_perr, s_ferr, s_ovr;
  logic [2:0] s_dbg_tx, s_dbg_rx;

  uart_core u_slow (
    .clk(clk), .reset(reset), .rx(s_rx), .tx(s_tx),
    .tx_data(s_tx_data), .tx_valid(s_tx_valid), .tx_ready(s_tx_ready),
    .rx_data(s_rx_data), .rx_valid(s_rx_valid), .rx_ready(s_rx_ready), .rx_count(s_rx_count),
    .cfg_speed(s_cfg_speed), .cfg_parity(s_cfg_parity), .cfg_stop2(s_cfg_stop2), .cfg_load(s_cfg_load),
    .parity_err(s_perr), .frame_err(s_ferr), .overrun(s_ovr),
    .o_dbg_tx_state(s_dbg_tx), .o_dbg_rx_state(s_dbg_rx)
  );

  // ---------------- fast instance ----------------
  logic       f_rx, f_tx, f_tx_valid, f_tx_ready, f_rx_valid, f_rx_ready;
  logic [7:0] f_tx_data, f_rx_data;
  logic [4:0] f_rx_count;
  logic [1:0] f_cfg_speed, f_cfg_parity;
  logic       f_cfg_stop2, f_cfg_load, f_perr, f_ferr, f_ovr;
  logic [2:0] f_dbg_tx, f_dbg_rx;

  uart_core #(.CLK_HZ(FAST_HZ)) u_fast (
    .clk(clk), .reset(reset), .rx(f_rx), .tx(f_tx),
    .tx_data(f_tx_data), .tx_valid(f_tx_valid), .tx_ready(f_tx_ready),
    .rx_data(f_rx_data), .rx_valid(f_rx_valid), .rx_ready(f_rx_ready), .rx_count(f_rx_count),
    .cfg_speed(f_cfg_speed), .cfg_parity(f_cfg_parity), .cfg_stop2(f_cfg_stop2), .cfg_load(f_cfg_load),
    .parity_err(f_perr), .frame_err(f_ferr), .overrun(f_ovr),
    .o_dbg_tx_state(f_dbg_tx), .o_dbg_rx_state(f_dbg_rx)
  );

  // Error pulse counters for the fast instance.
  int f_perr_n = 0;
  int f_ferr_n = 0;
  always @(posedge clk) begin
    if (f_perr) f_perr_n <= f_perr_n + 1;
    if (f_ferr) f_ferr_n <= f_ferr_n + 1;
  end

  // ---------------- scoreboard ----------------
  int         n_vec  = 0;
  int         n_miss = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic f_bit(input logic b);
    f_rx = b;
    repeat (FBIT) @(negedge clk);
  endtask

  // par_mode: 0 = no parity bit, 1 = correct even parity, 2 = wrong parity.
  task automatic f_send(input logic [7:0] d, input int par_mode, input logic stop);
    logic p;
    p = ^d;
    if (par_mode == 2) p = ~p;
    f_bit(1'b0);
    for (int i = 0; i < 8; i++) f_bit(d[i]);
    if (par_mode != 0) f_bit(p);
    f_bit(stop);
    f_bit(1'b1);
  endtask

  task automatic f_pop_check(input string name);
    logic [7:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    check({name, " valid"}, int'(f_rx_valid), 1);
    check({name, " head"}, int'(f_rx_data), int'(e));
    f_rx_ready = 1'b1;
    @(negedge clk);
    f_rx_ready = 1'b0;
  endtask

  task automatic wait_s_tx(input logic v, input int max, input string name);
    int k;
    k = 0;
    while (s_tx !== v && k < max) begin @(negedge clk); k++; end
    check(name, int'(s_tx), int'(v));
  endtask

  task automatic wait_s_ready(input int max, input string name);
    int k;
    k = 0;
    while (s_tx_ready !== 1'b1 && k < max) begin @(negedge clk); k++; end
    check(name, int'(s_tx_ready), 1);
  endtask

  task automatic s_start_byte(input logic [7:0] d);
    s_tx_data  = d;
    s_tx_valid = 1'b1;
    @(negedge clk);
    s_tx_valid = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // ---------------- RX vector table ----------------
  typedef struct {
    logic [7:0] data;
    int         par_mode;
    logic       stop;
    int         exp_perr;
    int         exp_ferr;
    int         exp_count;
    logic [7:0] exp_head;
  } rx_vec_t;

  rx_vec_t vecs[4];

  // ---------------- watchdog ----------------
  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int         t0, t_acc, p0, q0, stuck;
    logic [7:0] a5;
    a5 = 8'hA5;

    vecs[0] = '{8'h3C, 1, 1'b1, 0, 0, 1, 8'h3C};
    vecs[1] = '{8'h3C, 2, 1'b1, 1, 0, 2, 8'h3C};
    vecs[2] = '{8'h55, 1, 1'b0, 0, 1, 2, 8'h3C};
    vecs[3] = '{8'h12, 1, 1'b1, 0, 0, 3, 8'h3C};

    reset = 1'b0;
    s_rx = 1'b1; s_tx_data = '0; s_tx_valid = 1'b0; s_rx_ready = 1'b0;
    s_cfg_speed = 2'b11; s_cfg_parity = 2'b00; s_cfg_stop2 = 1'b0; s_cfg_load = 1'b0;
    f_rx = 1'b1; f_tx_data = '0; f_tx_valid = 1'b0; f_rx_ready = 1'b0;
    f_cfg_speed = 2'b11; f_cfg_parity = 2'b00; f_cfg_stop2 = 1'b0; f_cfg_load = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("reset tx", int'(s_tx), 1);
    check("reset tx_ready", int'(s_tx_ready), 1);
    check("reset rx_valid", int'(s_rx_valid), 0);
    check("reset rx_count", int'(s_rx_count), 0);
    check("reset err/overrun", int'({s_perr, s_ferr, s_ovr}), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // TX 0xA5 8N1 at 115200 (default after reset): 432 clocks per bit.
    s_start_byte(8'hA5);
    t_acc = cyc;
    check("tx_ready drop after accept", int'(s_tx_ready), 0);
    wait_s_tx(1'b0, 60, "tx start edge");
    t0 = cyc;
    wait_s_tx(1'b1, SBIT + 10, "tx start end");
    check("tx start bit length", cyc - t0, SBIT);
    for (int i = 0; i < 8; i++) begin
      wait_until(t0 + SBIT * (i + 1) + SBIT / 2);
      check($sformatf("tx A5 bit%0d", i), int'(s_tx), int'(a5[i]));
      check($sformatf("tx_ready low bit%0d", i), int'(s_tx_ready), 0);
    end
    wait_until(t0 + SBIT * 9 + SBIT / 2);
    check("tx stop bit", int'(s_tx), 1);
    wait_s_ready(SBIT + 10, "tx_ready return");
    check("tx fall to ready", cyc - t0, 10 * SBIT);
    check("tx_ready low span in range", int'((cyc - t_acc) >= 10 * SBIT && (cyc - t_acc) <= 10 * SBIT + 27), 1);

    // Reconfiguration requested mid-frame is deferred to the end of the frame.
    s_start_byte(8'h0F);
    wait_s_tx(1'b0, 60, "reconf frame1 start");
    t0 = cyc;
    repeat (100) @(negedge clk);
    s_cfg_speed = 2'b00; s_cfg_parity = 2'b00; s_cfg_stop2 = 1'b0; s_cfg_load = 1'b1;
    @(negedge clk);
    s_cfg_load = 1'b0;
    wait_s_ready(10 * SBIT, "reconf frame1 ready");
    check("reconf frame1 at 115200", cyc - t0, 10 * SBIT);
    s_start_byte(8'hFD);
    wait_s_tx(1'b0, 400, "reconf frame2 start");
    t0 = cyc;
    wait_s_tx(1'b1, SBIT0 + 10, "reconf frame2 start end");
    check("reconf frame2 start bit at 9600", cyc - t0, SBIT0);
    wait_until(t0 + SBIT0 * 2 + SBIT0 / 2);
    check("reconf frame2 bit1 low", int'(s_tx), 0);

    // Asynchronous reset in the middle of a low bit.
    reset = 1'b0;
    #1;
    check("midframe reset tx", int'(s_tx), 1);
    check("midframe reset tx_ready", int'(s_tx_ready), 1);
    check("midframe reset rx_count", int'(s_rx_count), 0);
    @(negedge clk);
    reset = 1'b1;
    stuck = 0;
    repeat (1000) begin
      @(negedge clk);
      if (s_tx !== 1'b1) stuck++;
    end
    check("idle tx after reset (low cycles)", stuck, 0);

    // Reset restores 115200.
    s_start_byte(8'hFF);
    wait_s_tx(1'b0, 60, "post-reset start");
    t0 = cyc;
    wait_s_tx(1'b1, SBIT + 10, "post-reset start end");
    check("post-reset start bit length", cyc - t0, SBIT);

    // ---------------- fast instance: RX, errors, FIFO ----------------
    f_cfg_speed = 2'b11; f_cfg_parity = 2'b01; f_cfg_stop2 = 1'b0; f_cfg_load = 1'b1;
    @(negedge clk);
    f_cfg_load = 1'b0;
    repeat (FBIT) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      p0 = f_perr_n;
      q0 = f_ferr_n;
      f_send(vecs[v].data, vecs[v].par_mode, vecs[v].stop);
      if (vecs[v].exp_ferr == 0) exp_q.push_back(vecs[v].data);
      check($sformatf("vec%0d parity_err pulses", v), f_perr_n - p0, vecs[v].exp_perr);
      check($sformatf("vec%0d frame_err pulses", v), f_ferr_n - q0, vecs[v].exp_ferr);
      check($sformatf("vec%0d rx_count", v), int'(f_rx_count), vecs[v].exp_count);
      check($sformatf("vec%0d head", v), int'(f_rx_data), int'(vecs[v].exp_head));
    end
    for (int i = 0; i < 3; i++) f_pop_check($sformatf("drain%0d", i));
    check("drained rx_count", int'(f_rx_count), 0);
    check("drained rx_valid", int'(f_rx_valid), 0);

    // False start: low for 4 ticks (8 clocks).
    q0 = f_ferr_n;
    f_rx = 1'b0;
    repeat (8) @(negedge clk);
    f_rx = 1'b1;
    repeat (3 * FBIT) @(negedge clk);
    check("false start rx_count", int'(f_rx_count), 0);
    check("false start rx state idle", int'(f_dbg_rx), 0);
    check("false start frame_err", f_ferr_n - q0, 0);

    // Overrun: 17 frames, no pops.
    for (int i = 0; i < 17; i++) begin
      f_send(8'(i), 1, 1'b1);
      if (i < 16) exp_q.push_back(8'(i));
      if (i == 15) check("full overrun still clear", int'(f_ovr), 0);
    end
    check("overrun rx_count", int'(f_rx_count), 16);
    check("overrun flag", int'(f_ovr), 1);
    f_pop_check("overrun head");
    check("overrun cleared by pop", int'(f_ovr), 0);
    check("overrun count after pop", int'(f_rx_count), 15);
    for (int i = 1; i < 16; i++) f_pop_check($sformatf("ovr drain%0d", i));
    check("ovr drained rx_count", int'(f_rx_count), 0);

    // rx_ready while empty is ignored.
    f_rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    f_rx_ready = 1'b0;
    check("pop when empty", int'(f_rx_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
